blake_round_ctrl: RTL and testbench
===================================

// Module: blake_round_ctrl
// PURPOSE
//  Sequencer for the single-G-core BLAKE-512 compression datapath.
//  Latches one 640-bit header, then steps the 7-bit step index through
//  16 rounds x 8 G steps. That index drives the downstream message/constant
//  mux as {round[3:0], step[2:0]}. Handshakes each G step with the G core,
//  then triggers finalization.
//  Sits between the top-level hash request interface and the v-register/G datapath.
// PARAMETERS
//  NROUNDS  16   rounds per block; the index ends at NROUNDS*8-1 (127)
//  MSG_W    640  width of latched message (10 x 64-bit words)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      request; accepted only in IDLE
//  msg_in       in   MSG_W  header; sampled in the start-accept cycle
//  busy         out  1      high from accept until done cycle inclusive
//  done         out  1      1-cycle pulse; hash result valid
//  msg_out      out  MSG_W  registered copy of msg_in, stable while busy
//  counter_idx  out  7      current step index to the message/constant mux
//  v_init       out  1      1-cycle pulse: load v[0:15] from h, salt, t
//  g_start      out  1      1-cycle pulse: G core consumes mux outputs
//  g_done       in   1      G core finished step (>=1 cycle after g_start)
//  final_en     out  1      1-cycle pulse: h' = h ^ s ^ v[0:7] ^ v[8:15]
//  abort        in   1      only with BLAKE_CTRL_ABORT_EN
//  aborted      out  1      only with BLAKE_CTRL_ABORT_EN; 1-cycle pulse
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; msg_out 0; counter_idx 0.
//  States: IDLE -> INIT -> ISSUE <-> WAIT -> FINAL -> DONE -> IDLE.
//  IDLE: on start, capture msg_out<=msg_in, set busy, go INIT.
//  INIT: v_init=1 for one cycle; counter_idx=0; go ISSUE.
//  ISSUE: g_start=1 for one cycle with counter_idx stable; go WAIT.
//  WAIT: hold counter_idx.
//   - On g_done with idx<127: idx+=1, go ISSUE.
//   - On g_done with idx==127: go FINAL.
//   - idx is never incremented past 127; no wrap.
//  FINAL: final_en=1 for one cycle; go DONE.
//  DONE: done=1, busy=1 for this cycle; next cycle IDLE, busy=0, idx=0.
//  Step period = L+1 cycles, where L = g_start-to-g_done latency.
//   Start accepted at cycle 0 -> done at cycle 4+127*(L+1)+L.
//  start while busy: ignored; no queueing.
//  start in the done cycle: ignored; re-issue from IDLE.
//  g_done outside WAIT (including the ISSUE cycle): ignored.
//  msg_in changes after accept: no effect on msg_out.
//  rst_n low mid-operation: immediate return to reset values; no done.
// CONFIGURATION
//  BLAKE_CTRL_ABORT_EN defined:
//   - abort in any non-IDLE state -> IDLE next cycle; busy=0; idx=0.
//   - aborted pulses 1 cycle; done, final_en and g_start are suppressed.
//   - abort in IDLE is ignored; abort beats start, g_done and done.
//   - A g_done arriving after abort is ignored.
//  BLAKE_CTRL_ABORT_EN undefined: abort/aborted ports absent; no abort path.
// STRUCTURE
//  blake_pkg.vh holds IDX_W=7, NSTEPS=128 and the state encodings
//   (IDLE, INIT, ISSUE, WAIT, FINAL, DONE).
//  It also holds the cb constants and sigma rows shared with the mux.
//  Sub-module blake_step_cnt is the 7-bit index register:
//   - inputs: clr, inc
//   - outputs: idx, last (idx==NSTEPS-1)
//   - saturates at last.
//  FSM, msg register and pulse outputs stay in blake_round_ctrl.
// TESTING
//  1. Reset, start=0 -> busy=0, done=0, counter_idx=0 for 20 cycles.
//  2. start with msg_in=640'h0123..; G model with L=1 ->
//     - v_init at cycle 1, first g_start at cycle 2;
//     - idx sequence 0..127, each exactly once;
//     - final_en at cycle 258, done at cycle 259.
//  3. L=3 with random 0-5 cycle jitter added ->
//     - idx advances only on accepted g_done;
//     - exactly 128 g_start pulses; done follows final_en by 1 cycle.
//  4. Pulse start at idx=40, drive msg_in=0 -> no restart; msg_out unchanged.
//  5. Drop rst_n at idx=100 -> all outputs 0 asynchronously;
//     - a fresh start completes normally.
//  6. ABORT_EN: assert abort in WAIT at idx=64 ->
//     - aborted pulse next cycle; busy=0; no done or final_en;
//     - the late g_done is ignored.

Source files
------------

// File: rtl/blake_pkg.sv
// Shared definitions for the BLAKE-512 round controller and message/constant mux:
// step-index geometry, controller state encoding, cb constants and sigma permutations.
package blake_pkg;

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned NSTEPS = 128;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StIssue,
    StWait,
    StFinal,
    StDone
  } state_e;

  localparam logic [63:0] CB [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
  };

  // One row per permutation, position 0 in the most significant nibble.
  localparam logic [63:0] SIGMA [10] = '{
    64'h0123456789abcdef, 64'hea489fd61c02b753, 64'hb8c052fdae367194, 64'h7931dcbe265a40f8,
    64'h905724afe1bc683d, 64'h2c6a0b834d75fe19, 64'hc51fed4a0763928b, 64'hdb7ec13950f4862a,
    64'h6fe9b308c2d714a5, 64'ha2847615fb9e3cd0
  };

  // Message word index for a given round and position; rounds 10..15 reuse rows 0..5.
  function automatic logic [3:0] sigma_sel(input logic [3:0] round, input logic [3:0] pos);
    logic [3:0]  row_sel;
    logic [63:0] row;
    row_sel = (round >= 4'd10) ? round - 4'd10 : round;
    row     = SIGMA[row_sel] >> {4'd15 - pos, 2'b00};
    return row[3:0];
  endfunction

endpackage

// File: rtl/blake_step_cnt.sv
// Step index register for the BLAKE round controller: clears, increments and
// saturates at the last step of the block.
module blake_step_cnt
  import blake_pkg::*;
#(
  parameter int unsigned LAST_IDX = NSTEPS - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q, idx_d;

  assign last = (idx_q == IDX_W'(LAST_IDX));
  assign idx  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc && !last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/blake_round_ctrl.sv
// Sequencer for the single-G-core BLAKE-512 compression datapath.
// Optional abort path enabled by defining BLAKE_CTRL_ABORT_EN.
module blake_round_ctrl
  import blake_pkg::*;
#(
  parameter int unsigned NROUNDS = 16,
  parameter int unsigned MSG_W   = 640
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MSG_W-1:0] msg_in,
  input  logic             g_done,
`ifdef BLAKE_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic [MSG_W-1:0] msg_out,
  output logic [IDX_W-1:0] counter_idx,
  output logic             v_init,
  output logic             g_start,
  output logic             final_en
);

  state_e           state_q, state_d;
  logic [MSG_W-1:0] msg_q;
  logic             abort_hit;
  logic             cnt_clr, cnt_inc, cnt_last;

`ifdef BLAKE_CTRL_ABORT_EN
  logic aborted_q;

  assign abort_hit = abort && (state_q != StIdle);
  assign aborted   = aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StInit;
      StInit:  state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (g_done) state_d = cnt_last ? StFinal : StIssue;
      StFinal: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over every other transition.
    if (abort_hit) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) msg_q <= msg_in;
    end
  end

  // Index returns to zero on the cycle after DONE or abort; held everywhere else.
  assign cnt_clr = (state_q == StIdle) || (state_q == StDone) || abort_hit;
  assign cnt_inc = (state_q == StWait) && g_done && !abort_hit;

  blake_step_cnt #(
    .LAST_IDX (NROUNDS * 8 - 1)
  ) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .idx   (counter_idx),
    .last  (cnt_last)
  );

  always_comb begin
    busy     = (state_q != StIdle);
    v_init   = (state_q == StInit);
    g_start  = (state_q == StIssue) && !abort_hit;
    final_en = (state_q == StFinal) && !abort_hit;
    done     = (state_q == StDone) && !abort_hit;
  end

  assign msg_out = msg_q;

endmodule

// File: tb/tb_blake_round_ctrl.sv
// Scoreboard bench for blake_round_ctrl: randomized headers and G-core latency,
// expected step order and completion timing derived from the round/step schedule.
module tb_blake_round_ctrl;
  import blake_pkg::*;

  localparam int MSG_W = 640;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [MSG_W-1:0] msg_in = '0;
  logic             g_done = 1'b0;
  logic             busy, done, v_init, g_start, final_en;
  logic [MSG_W-1:0] msg_out;
  logic [IDX_W-1:0] counter_idx;
`ifdef BLAKE_CTRL_ABORT_EN
  logic             abort = 1'b0;
  logic             aborted;
`endif

  blake_round_ctrl #(
    .NROUNDS (16),
    .MSG_W   (MSG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .msg_in      (msg_in),
    .g_done      (g_done),
`ifdef BLAKE_CTRL_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .busy        (busy),
    .done        (done),
    .msg_out     (msg_out),
    .counter_idx (counter_idx),
    .v_init      (v_init),
    .g_start     (g_start),
    .final_en    (final_en)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int g_lat = 1;
  bit g_jit = 1'b0;

  typedef struct {
    logic [MSG_W-1:0] msg;
    int               done_rel;  // -1 when latency is jittered
  } txn_t;

  int   exp_idx[$];
  txn_t exp_txn[$];

  task automatic check(input string name, input logic [MSG_W-1:0] act,
                       input logic [MSG_W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event occurred where none was required", name);
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m;
    for (int i = 0; i < MSG_W / 32; i++) m[i*32 +: 32] = $urandom();
    return m;
  endfunction

  // G core model: answers each g_start after g_lat (+ optional jitter) cycles.
  always begin : g_model
    int n;
    @(negedge clk);
    if (g_start) begin
      n = g_lat + (g_jit ? int'($urandom_range(0, 5)) : 0);
      repeat (n) @(posedge clk);
      #1 g_done = 1'b1;
      @(posedge clk);
      #1 g_done = 1'b0;
    end
  end

  // Monitor: rel counts cycles since accept (INIT is cycle 1).
  int rel = 0;
  bit busy_prev = 1'b0, final_prev = 1'b0, gs_prev = 1'b0;

  always @(negedge clk) begin : monitor
    txn_t t;
    int   e;
    if (busy && !busy_prev) rel = 1;
    else if (busy) rel++;
    if (v_init) check("v_init_cycle", rel, 1);
    if (g_start) begin
      check("g_start_single", gs_prev, 0);
      if (exp_idx.size() == 0) begin
        flag("unexpected_g_start");
      end else begin
        e = exp_idx.pop_front();
        check("g_start_idx", counter_idx, e);
        if (e == 0) check("first_g_start_cycle", rel, 2);
      end
      if (exp_txn.size() > 0) check("msg_hold", msg_out, exp_txn[0].msg);
    end
    if (final_en && exp_txn.size() > 0 && exp_txn[0].done_rel >= 0)
      check("final_cycle", rel, exp_txn[0].done_rel - 1);
    if (done) begin
      check("done_after_final", final_prev, 1);
      if (exp_txn.size() == 0) begin
        flag("unexpected_done");
      end else begin
        t = exp_txn.pop_front();
        check("done_msg", msg_out, t.msg);
        check("steps_left", exp_idx.size(), 0);
        if (t.done_rel >= 0) check("done_cycle", rel, t.done_rel);
      end
    end
    busy_prev  = busy;
    final_prev = final_en;
    gs_prev    = g_start;
  end

  // Reference: every round visits steps 0..7 in order, index = round*8 + step.
  task automatic issue(input logic [MSG_W-1:0] m);
    txn_t t;
    @(posedge clk);
    #1;
    start  = 1'b1;
    msg_in = m;
    for (int r = 0; r < 16; r++)
      for (int s = 0; s < 8; s++) exp_idx.push_back(r * 8 + s);
    t.msg      = m;
    t.done_rel = g_jit ? -1 : 4 + 127 * (g_lat + 1) + g_lat;
    exp_txn.push_back(t);
    @(posedge clk);
    #1;
    start  = 1'b0;
    msg_in = ~m;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: actual busy required idle", name);
    end
    #1;
  endtask

  task automatic wait_idx(input int v, input bit need_gs);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(int'(counter_idx) == v && (!need_gs || g_start)) && n < 5000);
    if (n >= 5000) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idx_timeout: actual %0d required %0d", counter_idx, v);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_idx", counter_idx, 0);
    end
    check("idle_msg", msg_out, 0);
    check("idle_pulses", {v_init, g_start, final_en}, 0);

    // Fixed latency 1, known header.
    g_lat = 1;
    g_jit = 1'b0;
    issue({10{64'h0123456789abcdef}});
    wait_idle("l1");
    check("after_done_idx", counter_idx, 0);

    // Jittered latency: order and count still hold.
    g_lat = 3;
    g_jit = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(rand_msg());
      wait_idle("jitter");
    end

    g_lat = 2;
    g_jit = 1'b0;
    issue(rand_msg());
    wait_idle("l2");

    // Start while busy is ignored.
    g_lat = 1;
    issue(rand_msg());
    wait_idx(40, 1'b0);
    @(posedge clk);
    #1;
    start  = 1'b1;
    msg_in = '0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle("busy_start");

    // Asynchronous reset mid-block.
    issue(rand_msg());
    wait_idx(100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", counter_idx, 0);
    check("rst_msg", msg_out, 0);
    check("rst_pulses", {v_init, g_start, final_en}, 0);
    exp_idx.delete();
    exp_txn.delete();
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    issue(rand_msg());
    wait_idle("post_rst");

`ifdef BLAKE_CTRL_ABORT_EN
    g_lat = 3;
    issue(rand_msg());
    wait_idx(64, 1'b1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    exp_idx.delete();
    exp_txn.delete();
    check("abort_pulse", aborted, 1);
    check("abort_busy", busy, 0);
    check("abort_idx", counter_idx, 0);
    @(posedge clk);
    #1 check("abort_pulse_end", aborted, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_stay_idle", busy, 0);
      check("abort_no_final", final_en, 0);
    end
    g_lat = 1;
    issue(rand_msg());
    wait_idle("post_abort");
`endif

    repeat (5) @(posedge clk);
    check("queues_drained", exp_idx.size() + exp_txn.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
